// File: rtl/clock_set_ctrl.sv
// Edit-mode controller for the calendar clock: button-driven field selection, pause and switch controls.
// Optional inactivity timeout back to run mode is built when CLOCK_SET_TIMEOUT_EN is defined.
module clock_set_ctrl #(
    parameter int TIMEOUT_TICKS = 20,
    parameter int TO_W          = 5
) (
    input  logic       clk,
    input  logic       rst_p,
    input  logic       tick_half,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       pause,
    output logic       switch_second,
    output logic       switch_minute,
    output logic       switch_hour,
    output logic       switch_day,
    output logic       switch_month,
    output logic       switch_year,
    output logic [2:0] field_sel,
    output logic       blink
);

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_SEC   = 3'd1,
        ST_MIN   = 3'd2,
        ST_HOUR  = 3'd3,
        ST_DAY   = 3'd4,
        ST_MONTH = 3'd5,
        ST_YEAR  = 3'd6
    } state_t;

    state_t     state_r;
    state_t     state_next_s;
    logic       btn_mode_q_r;
    logic       mode_edge_s;
    logic       inc_lock_r;
    logic       inc_lock_next_s;
    logic       blink_r;
    logic       blink_next_s;
    logic       pause_r;
    logic [5:0] switch_r;
    logic [5:0] switch_next_s;
    logic       timeout_s;

    // Out-of-range parameters elaborate to nothing; the check keeps both parameters referenced in every build.
    if ((TIMEOUT_TICKS < 1) || (TIMEOUT_TICKS > (1 << TO_W))) begin : g_param_range_bad
    end

    assign mode_edge_s = btn_mode & ~btn_mode_q_r;

`ifdef CLOCK_SET_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_r;

    // Button activity in the same cycle as the final strobe counts as activity, so no timeout then.
    assign timeout_s = (state_r != ST_RUN) & tick_half & ~btn_inc & ~mode_edge_s
                       & (to_cnt_r == TO_W'(TIMEOUT_TICKS - 1));

    // Inactivity counter: counts half-second strobes while editing with no button activity.
    always_ff @(posedge clk) begin
        if (rst_p) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if ((state_r == ST_RUN) || mode_edge_s || btn_inc || timeout_s) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if (tick_half) begin
            to_cnt_r <= to_cnt_r + TO_W'(1'b1);
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next field: mode edges walk the ring, timeout falls back to run.
    always_comb begin
        state_next_s = state_r;
        if (mode_edge_s) begin
            case (state_r)
                ST_RUN:   state_next_s = ST_SEC;
                ST_SEC:   state_next_s = ST_MIN;
                ST_MIN:   state_next_s = ST_HOUR;
                ST_HOUR:  state_next_s = ST_DAY;
                ST_DAY:   state_next_s = ST_MONTH;
                ST_MONTH: state_next_s = ST_YEAR;
                ST_YEAR:  state_next_s = ST_RUN;
                default:  state_next_s = ST_RUN;
            endcase
        end else if (timeout_s) begin
            state_next_s = ST_RUN;
        end else begin
            state_next_s = state_r;
        end
    end

    // Next lock, blink and switch values; the lock uses its next value so a held increment never edits the new field.
    always_comb begin
        inc_lock_next_s = inc_lock_r;
        blink_next_s    = blink_r;
        switch_next_s   = 6'b000000;

        if (!btn_inc) begin
            inc_lock_next_s = 1'b0;
        end else if (mode_edge_s) begin
            inc_lock_next_s = 1'b1;
        end else begin
            inc_lock_next_s = inc_lock_r;
        end

        if (state_next_s == ST_RUN) begin
            blink_next_s = 1'b0;
        end else if (state_next_s != state_r) begin
            blink_next_s = 1'b1;
        end else if (tick_half) begin
            blink_next_s = ~blink_r;
        end else begin
            blink_next_s = blink_r;
        end

        if (btn_inc && !inc_lock_next_s) begin
            case (state_next_s)
                ST_SEC:   switch_next_s = 6'b000001;
                ST_MIN:   switch_next_s = 6'b000010;
                ST_HOUR:  switch_next_s = 6'b000100;
                ST_DAY:   switch_next_s = 6'b001000;
                ST_MONTH: switch_next_s = 6'b010000;
                ST_YEAR:  switch_next_s = 6'b100000;
                default:  switch_next_s = 6'b000000;
            endcase
        end else begin
            switch_next_s = 6'b000000;
        end
    end

    // Registered state and outputs.
    always_ff @(posedge clk) begin
        if (rst_p) begin
            state_r      <= ST_RUN;
            btn_mode_q_r <= 1'b1;
            inc_lock_r   <= 1'b0;
            blink_r      <= 1'b0;
            pause_r      <= 1'b0;
            switch_r     <= 6'b000000;
        end else begin
            state_r      <= state_next_s;
            btn_mode_q_r <= btn_mode;
            inc_lock_r   <= inc_lock_next_s;
            blink_r      <= blink_next_s;
            pause_r      <= (state_next_s != ST_RUN);
            switch_r     <= switch_next_s;
        end
    end

    assign field_sel     = state_r;
    assign pause         = pause_r;
    assign blink         = blink_r;
    assign switch_second = switch_r[0];
    assign switch_minute = switch_r[1];
    assign switch_hour   = switch_r[2];
    assign switch_day    = switch_r[3];
    assign switch_month  = switch_r[4];
    assign switch_year   = switch_r[5];

endmodule
